// File: rtl/rewind_loop_status_monitor_if.sv
// Observed signals of the monitored HLS module: block handshake plus loop FSM state and event qualifiers.
// The monitored design drives these (master); the status monitor only reads them (slave).
interface rewind_loop_status_monitor_if #(
    parameter int STATE_W = 2
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] iter_start_state;
    logic [STATE_W-1:0] iter_end_state;
    logic [STATE_W-1:0] quit_state;
    logic               iter_start_enable;
    logic               iter_start_block;
    logic               iter_end_enable;
    logic               iter_end_block;
    logic               quit_enable;
    logic               quit_block;
    logic               quit_at_end;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output cur_state, iter_start_state, iter_end_state, quit_state,
        output iter_start_enable, iter_start_block,
        output iter_end_enable, iter_end_block,
        output quit_enable, quit_block, quit_at_end
    );

    modport slave (
        input ap_start, ap_ready, ap_done, ap_continue,
        input cur_state, iter_start_state, iter_end_state, quit_state,
        input iter_start_enable, iter_start_block,
        input iter_end_enable, iter_end_block,
        input quit_enable, quit_block, quit_at_end
    );
endinterface

// File: rtl/rewind_loop_status_monitor.sv
// Observe-only statistics monitor for an HLS block handshake and one pipelined rewind loop.
// Optional: define MON_PROTOCOL_CHECK_EN to build the sticky protocol error flags on err.
module rewind_loop_status_monitor #(
    parameter int STATE_W = 2,
    parameter int CNT_W   = 32,
    parameter int DEPTH   = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    rewind_loop_status_monitor_if.slave bus,
    input  logic                        finish,
    output logic                        module_busy,
    output logic [CNT_W-1:0]            txn_count,
    output logic [CNT_W-1:0]            iter_count,
    output logic [3:0]                  in_flight,
    output logic [CNT_W-1:0]            last_latency,
    output logic [CNT_W-1:0]            last_ii,
    output logic [CNT_W-1:0]            max_ii,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic                        frozen,
    output logic [1:0]                  err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } txn_state_t;

    txn_state_t state, next_state;

    logic [STATE_W-1:0] cur_state;
    logic               unused_ap_ready;
    logic               s_evt, e_evt, q_evt, q_eff, stall_evt, done_ack;
    logic               txn_begin, txn_end;
    logic [CNT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   ii_cnt;
    logic               first_seen;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cur_state       = bus.cur_state;
    assign unused_ap_ready = bus.ap_ready;

    assign s_evt     = (cur_state == bus.iter_start_state) & bus.iter_start_enable & ~bus.iter_start_block;
    assign e_evt     = (cur_state == bus.iter_end_state) & bus.iter_end_enable & ~bus.iter_end_block;
    assign q_evt     = (cur_state == bus.quit_state) & bus.quit_enable & ~bus.quit_block;
    assign stall_evt = (cur_state == bus.iter_start_state) & bus.iter_start_enable & bus.iter_start_block;
    // A quit flagged as end-of-loop only takes effect together with the final iteration end.
    assign q_eff     = q_evt & (~bus.quit_at_end | e_evt);
    assign done_ack  = bus.ap_done & bus.ap_continue;

    assign module_busy = (state == BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start and an acknowledged done in the same idle cycle is a complete 1-cycle transaction.
    always_comb begin
        next_state = state;
        txn_begin  = 1'b0;
        txn_end    = 1'b0;
        if (!frozen) begin
            case (state)
                IDLE: begin
                    if (bus.ap_start) begin
                        txn_begin = 1'b1;
                        if (done_ack) begin
                            txn_end = 1'b1;
                        end else begin
                            next_state = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (done_ack) begin
                        txn_end = 1'b1;
                        if (bus.ap_start) begin
                            txn_begin = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // lat_cnt counts cycles already spent; the done cycle itself adds one more.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_cnt      <= '0;
            last_latency <= '0;
            txn_count    <= '0;
        end else if (!frozen) begin
            if (txn_end) begin
                txn_count    <= sat_inc(txn_count);
                last_latency <= (state == IDLE) ? CNT_W'(1) : sat_inc(lat_cnt);
            end
            if (txn_begin) begin
                lat_cnt <= CNT_W'(1);
            end else if (state == BUSY) begin
                lat_cnt <= sat_inc(lat_cnt);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ii_cnt       <= '0;
            last_ii      <= '0;
            max_ii       <= '0;
            first_seen   <= 1'b0;
            in_flight    <= 4'd0;
            iter_count   <= '0;
            stall_cycles <= '0;
            frozen       <= 1'b0;
        end else if (!frozen) begin
            if (s_evt) begin
                ii_cnt <= CNT_W'(1);
                if (first_seen && !txn_begin) begin
                    last_ii <= ii_cnt;
                    max_ii  <= (ii_cnt > max_ii) ? ii_cnt : max_ii;
                end
            end else begin
                ii_cnt <= sat_inc(ii_cnt);
            end

            if (q_eff) begin
                first_seen <= 1'b0;
            end else if (s_evt) begin
                first_seen <= 1'b1;
            end else if (txn_begin) begin
                first_seen <= 1'b0;
            end

            if (s_evt && !e_evt && in_flight != 4'd15) begin
                in_flight <= in_flight + 4'd1;
            end else if (e_evt && !s_evt && in_flight != 4'd0) begin
                in_flight <= in_flight - 4'd1;
            end

            if (e_evt) begin
                iter_count <= sat_inc(iter_count);
            end
            if (stall_evt) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (finish) begin
                frozen <= 1'b1;
            end
        end
    end

`ifdef MON_PROTOCOL_CHECK_EN
    localparam logic [4:0] DEPTH_LIMIT = 5'(DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 2'b00;
        end else if (!frozen) begin
            if (e_evt && !s_evt && in_flight == 4'd0) begin
                err[0] <= 1'b1;
            end
            if ((s_evt && !e_evt && ({1'b0, in_flight} >= DEPTH_LIMIT)) ||
                (state == IDLE && bus.ap_done && !bus.ap_start)) begin
                err[1] <= 1'b1;
            end
        end
    end
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_rewind_loop_status_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-timestamp reference model.
module tb_rewind_loop_status_monitor;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 32;
    localparam int DEPTH   = 6;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic finish = 1'b0;

    logic             module_busy;
    logic [CNT_W-1:0] txn_count, iter_count, last_latency, last_ii, max_ii, stall_cycles;
    logic [3:0]       in_flight;
    logic             frozen;
    logic [1:0]       err;

    rewind_loop_status_monitor_if #(.STATE_W(STATE_W)) bus ();

    rewind_loop_status_monitor #(
        .STATE_W(STATE_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .finish      (finish),
        .module_busy (module_busy),
        .txn_count   (txn_count),
        .iter_count  (iter_count),
        .in_flight   (in_flight),
        .last_latency(last_latency),
        .last_ii     (last_ii),
        .max_ii      (max_ii),
        .stall_cycles(stall_cycles),
        .frozen      (frozen),
        .err         (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int peak   = 0;
    longint unsigned cycle = 0;

    // Reference model: transactions and II are derived from cycle timestamps.
    bit              mBusy, mFrozen, mScore;
    longint unsigned mStartCycle, mLastS;
    longint unsigned mTxn, mIter, mLastLat, mLastII, mMaxII, mStall;
    int              mInFlight;
    logic [1:0]      mErr;

    function automatic longint unsigned satInc(input longint unsigned v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic modelReset();
        mBusy = 0; mFrozen = 0; mScore = 0;
        mStartCycle = 0; mLastS = 0;
        mTxn = 0; mIter = 0; mLastLat = 0; mLastII = 0; mMaxII = 0; mStall = 0;
        mInFlight = 0; mErr = 2'b00;
    endtask

    task automatic modelStep();
        bit s, e, q, qe, st, doneAck, beginTxn;
        if (reset && !mFrozen) begin
            s  = (bus.cur_state == bus.iter_start_state) && bus.iter_start_enable && !bus.iter_start_block;
            e  = (bus.cur_state == bus.iter_end_state) && bus.iter_end_enable && !bus.iter_end_block;
            q  = (bus.cur_state == bus.quit_state) && bus.quit_enable && !bus.quit_block;
            st = (bus.cur_state == bus.iter_start_state) && bus.iter_start_enable && bus.iter_start_block;
            qe = q && (!bus.quit_at_end || e);
            doneAck  = bus.ap_done && bus.ap_continue;
            beginTxn = 0;
`ifdef MON_PROTOCOL_CHECK_EN
            if (e && !s && mInFlight == 0) mErr[0] = 1'b1;
            if ((s && !e && mInFlight + 1 > DEPTH) || (!mBusy && bus.ap_done && !bus.ap_start)) mErr[1] = 1'b1;
`endif
            if (!mBusy) begin
                if (bus.ap_start) begin
                    beginTxn = 1;
                    if (doneAck) begin
                        mTxn = satInc(mTxn);
                        mLastLat = 1;
                    end else begin
                        mBusy = 1;
                        mStartCycle = cycle;
                    end
                end
            end else if (doneAck) begin
                mTxn = satInc(mTxn);
                mLastLat = cycle - mStartCycle + 1;
                if (bus.ap_start) begin
                    beginTxn = 1;
                    mStartCycle = cycle;
                end else begin
                    mBusy = 0;
                end
            end
            if (s) begin
                if (mScore && !beginTxn) begin
                    mLastII = cycle - mLastS;
                    if (mLastII > mMaxII) mMaxII = mLastII;
                end
                mLastS = cycle;
            end
            if (qe) mScore = 0;
            else if (s) mScore = 1;
            else if (beginTxn) mScore = 0;
            if (s && !e && mInFlight < 15) mInFlight++;
            else if (e && !s && mInFlight > 0) mInFlight--;
            if (e) mIter = satInc(mIter);
            if (st) mStall = satInc(mStall);
            if (finish) mFrozen = 1;
        end
        cycle++;
    endtask

    task automatic checkValue(input string tag, input string name,
                              input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s %s: observed %0d expected %0d", tag, name, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue(tag, "module_busy", 64'(module_busy), 64'(mBusy));
        checkValue(tag, "txn_count", 64'(txn_count), mTxn);
        checkValue(tag, "iter_count", 64'(iter_count), mIter);
        checkValue(tag, "in_flight", 64'(in_flight), 64'(mInFlight));
        checkValue(tag, "last_latency", 64'(last_latency), mLastLat);
        checkValue(tag, "last_ii", 64'(last_ii), mLastII);
        checkValue(tag, "max_ii", 64'(max_ii), mMaxII);
        checkValue(tag, "stall_cycles", 64'(stall_cycles), mStall);
        checkValue(tag, "frozen", 64'(frozen), 64'(mFrozen));
        checkValue(tag, "err", 64'(err), 64'(mErr));
    endtask

    task automatic applyStimulus(input string tag);
        modelStep();
        @(posedge clock);
        #1;
        if (int'(in_flight) > peak) peak = int'(in_flight);
        checkOutput(tag);
    endtask

    task automatic clearInputs();
        bus.ap_start = 0; bus.ap_ready = 0; bus.ap_done = 0; bus.ap_continue = 0;
        bus.iter_start_enable = 0; bus.iter_start_block = 0;
        bus.iter_end_enable = 0; bus.iter_end_block = 0;
        bus.quit_enable = 0; bus.quit_block = 0; bus.quit_at_end = 0;
        finish = 0;
    endtask

    task automatic setAllStates(input logic [STATE_W-1:0] v);
        bus.cur_state = v; bus.iter_start_state = v; bus.iter_end_state = v; bus.quit_state = v;
    endtask

    task automatic doReset();
        #2 reset = 0;
        #1 modelReset();
        #2 reset = 1;
        clearInputs();
    endtask

    task automatic doTxn(input int busyCycles, input string tag);
        bus.ap_start = 1;
        applyStimulus(tag);
        bus.ap_start = 0;
        repeat (busyCycles) applyStimulus(tag);
        bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus(tag);
        bus.ap_done = 0; bus.ap_continue = 0;
    endtask

    initial begin
        clearInputs();
        setAllStates(2'd1);
        modelReset();
        #12;
        checkOutput("reset");
        reset = 1;

        // Three transactions, then an asynchronous reset in the middle of a fourth.
        for (int i = 0; i < 3; i++) doTxn(2, "pre_reset");
        checkValue("pre_reset", "txn_count", 64'(txn_count), 64'd3);
        bus.ap_start = 1;
        applyStimulus("fourth_txn");
        bus.ap_start = 0;
        applyStimulus("fourth_txn");
        #2 reset = 0;
        #1 modelReset();
        checkOutput("async_reset");
        clearInputs();
        applyStimulus("in_reset");
        reset = 1;
        applyStimulus("after_release");
        checkValue("after_release", "module_busy", 64'(module_busy), 64'd0);

        // Back-to-back transactions of 11 cycles each.
        bus.ap_start = 1;
        applyStimulus("b2b");
        bus.ap_start = 0;
        repeat (9) applyStimulus("b2b");
        bus.ap_start = 1; bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("b2b_boundary");
        checkValue("b2b_boundary", "last_latency", 64'(last_latency), 64'd11);
        checkValue("b2b_boundary", "module_busy", 64'(module_busy), 64'd1);
        clearInputs();
        repeat (9) applyStimulus("b2b");
        bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("b2b_end");
        clearInputs();
        checkValue("b2b_end", "txn_count", 64'(txn_count), 64'd2);
        checkValue("b2b_end", "last_latency", 64'(last_latency), 64'd11);

        // Pipelined loop at II=1, ends trailing starts so that DEPTH iterations overlap.
        bus.ap_start = 1;
        applyStimulus("pipe");
        bus.ap_start = 0;
        peak = 0;
        for (int t = 0; t < 14; t++) begin
            bus.iter_start_enable = (t < 8);
            bus.iter_end_enable   = (t >= DEPTH) && (t < DEPTH + 8);
            applyStimulus("pipe");
        end
        clearInputs();
        checkValue("pipe", "iter_count", 64'(iter_count), 64'd8);
        checkValue("pipe", "last_ii", 64'(last_ii), 64'd1);
        checkValue("pipe", "max_ii", 64'(max_ii), 64'd1);
        checkValue("pipe", "peak_in_flight", 64'(peak), 64'(DEPTH));
        checkValue("pipe", "in_flight", 64'(in_flight), 64'd0);
        bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("pipe_done");
        clearInputs();

        // Three blocked start cycles stretch one initiation interval to 4.
        bus.ap_start = 1;
        applyStimulus("stall");
        bus.ap_start = 0;
        bus.iter_start_enable = 1;
        repeat (2) applyStimulus("stall");
        bus.iter_start_block = 1;
        repeat (3) applyStimulus("stall");
        bus.iter_start_block = 0;
        applyStimulus("stall");
        checkValue("stall", "stall_cycles", 64'(stall_cycles), 64'd3);
        checkValue("stall", "last_ii", 64'(last_ii), 64'd4);
        checkValue("stall", "max_ii", 64'(max_ii), 64'd4);
        bus.iter_start_enable = 0;
        bus.iter_end_enable = 1;
        repeat (3) applyStimulus("stall_drain");
        clearInputs();
        bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("stall_done");
        clearInputs();

        // Protocol violations: end without start, then overfilling the pipeline to saturation.
        doReset();
        bus.iter_end_enable = 1;
        applyStimulus("proto_end");
        bus.iter_end_enable = 0;
`ifdef MON_PROTOCOL_CHECK_EN
        checkValue("proto_end", "err", 64'(err), 64'd1);
`else
        checkValue("proto_end", "err", 64'(err), 64'd0);
`endif
        bus.iter_start_enable = 1;
        repeat (7) applyStimulus("proto_over");
`ifdef MON_PROTOCOL_CHECK_EN
        checkValue("proto_over", "err", 64'(err), 64'd3);
`else
        checkValue("proto_over", "err", 64'(err), 64'd0);
`endif
        repeat (9) applyStimulus("proto_sat");
        checkValue("proto_sat", "in_flight", 64'(in_flight), 64'd15);
        clearInputs();

        // Random traffic against the model.
        doReset();
        bus.iter_start_state = 2'($urandom_range(3));
        bus.iter_end_state   = 2'($urandom_range(3));
        bus.quit_state       = 2'($urandom_range(3));
        for (int i = 0; i < 400; i++) begin
            bus.ap_start          = ($urandom_range(7) == 0);
            bus.ap_done           = ($urandom_range(5) == 0);
            bus.ap_continue       = ($urandom_range(3) != 0);
            bus.ap_ready          = ($urandom_range(1) == 1);
            bus.cur_state         = 2'($urandom_range(3));
            bus.iter_start_enable = ($urandom_range(1) == 1);
            bus.iter_start_block  = ($urandom_range(3) == 0);
            bus.iter_end_enable   = ($urandom_range(2) == 0);
            bus.iter_end_block    = ($urandom_range(3) == 0);
            bus.quit_enable       = !bus.iter_start_enable && ($urandom_range(4) == 0);
            bus.quit_block        = ($urandom_range(3) == 0);
            bus.quit_at_end       = ($urandom_range(1) == 1);
            applyStimulus("random");
        end
        clearInputs();

        // Freeze: events on the finish edge count, nothing afterwards does.
        doReset();
        setAllStates(2'd1);
        bus.ap_start = 1;
        applyStimulus("fin_txn1");
        bus.ap_start = 0;
        bus.iter_start_enable = 1;
        repeat (2) applyStimulus("fin_txn1");
        bus.iter_start_enable = 0;
        bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("fin_txn1");
        clearInputs();
        bus.ap_start = 1;
        applyStimulus("fin_txn2");
        bus.ap_start = 0;
        bus.iter_end_enable = 1;
        repeat (2) applyStimulus("fin_txn2");
        bus.ap_done = 1; bus.ap_continue = 1; finish = 1;
        applyStimulus("fin_edge");
        clearInputs();
        for (int i = 0; i < 5; i++) begin
            bus.iter_start_enable = (i % 2 == 0);
            bus.iter_end_enable   = (i % 2 == 1);
            applyStimulus("frozen_events");
        end
        clearInputs();
        bus.ap_start = 1; bus.ap_done = 1; bus.ap_continue = 1;
        applyStimulus("frozen_done");
        clearInputs();
        checkValue("frozen", "txn_count", 64'(txn_count), 64'd2);
        checkValue("frozen", "iter_count", 64'(iter_count), 64'd3);
        checkValue("frozen", "frozen", 64'(frozen), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
